// File: rtl/addsub_datapath_mc_if.sv
// Instruction handshake between the decode/control unit (master) and the
// multi-cycle ADD-SUB datapath (slave).
interface addsub_datapath_mc_if #(
    parameter int XLEN  = 64,
    parameter int NREG  = 32,
    parameter int IMM_W = 12
);
    localparam int RW = $clog2(NREG);

    logic             start;
    logic [2:0]       op;
    logic [RW-1:0]    rs1;
    logic [RW-1:0]    rs2;
    logic [RW-1:0]    rd;
    logic [IMM_W-1:0] immediate;
    logic             ready;
    logic             done;
    logic             err;
    logic [XLEN-1:0]  result;

    modport master (
        output start, op, rs1, rs2, rd, immediate,
        input  ready, done, err, result
    );

    modport slave (
        input  start, op, rs1, rs2, rd, immediate,
        output ready, done, err, result
    );
endinterface

// File: rtl/addsub_datapath_mc.sv
// Multi-cycle ADD/SUB/ADDI/LD/SD datapath with private register file and data
// memory, sequenced IDLE -> READ -> EXEC -> [MEM] -> WB under a start/done handshake.
module addsub_datapath_mc #(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int DM_DEPTH = 32,
    parameter int IMM_W    = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    addsub_datapath_mc_if.slave  bus
);
    localparam int RW = $clog2(NREG);
    localparam int AW = $clog2(DM_DEPTH);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_ADDI = 3'd2,
        OP_LD   = 3'd3,
        OP_SD   = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    state_e           state;
    logic [2:0]       op_q;
    logic [RW-1:0]    rs1_q, rs2_q, rd_q;
    logic [IMM_W-1:0] imm_q;
    logic [XLEN-1:0]  a_q, b_q, alu_q, mdr_q;
    logic             ready_q, done_q, err_q;
    logic [XLEN-1:0]  result_q;

    logic [XLEN-1:0]  regs [NREG];
    logic [XLEN-1:0]  mem  [DM_DEPTH];

    logic [XLEN-1:0]  imm_ext, op2, alu_val;
    logic [AW-1:0]    addr;
    logic             illegal, oob, writes_rf;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        imm_ext   = {{(XLEN-IMM_W){imm_q[IMM_W-1]}}, imm_q};
        op2       = b_q;
        if (op_q inside {OP_ADDI, OP_LD, OP_SD})
            op2 = imm_ext;
        alu_val   = (op_q == OP_SUB) ? a_q - b_q : a_q + op2;
        illegal   = (op_q > OP_SD);
        addr      = alu_q[AW-1:0];
        oob       = (alu_q >= XLEN'(DM_DEPTH));
        writes_rf = op_q inside {OP_ADD, OP_SUB, OP_ADDI, OP_LD};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        rs1_q   <= bus.rs1;
                        rs2_q   <= bus.rs2;
                        rd_q    <= bus.rd;
                        imm_q   <= bus.immediate;
                        ready_q <= 1'b0;
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    a_q   <= (rs1_q == '0) ? '0 : regs[rs1_q];
                    b_q   <= (rs2_q == '0) ? '0 : regs[rs2_q];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    alu_q <= alu_val;
                    if (op_q == OP_LD || op_q == OP_SD) begin
                        state <= S_MEM;
                    end else begin
                        state    <= S_WB;
                        done_q   <= 1'b1;
                        err_q    <= illegal;
                        result_q <= illegal ? '0 : alu_val;
                    end
                end
                S_MEM: begin
                    state  <= S_WB;
                    done_q <= 1'b1;
                    err_q  <= oob;
                    // A suppressed load leaves MDR untouched, so result shows its previous contents.
                    if (op_q == OP_LD) begin
                        if (!oob)
                            mdr_q <= mem[addr];
                        result_q <= oob ? mdr_q : mem[addr];
                    end else begin
                        result_q <= alu_q;
                    end
                end
                S_WB: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= S_IDLE;
                    if (writes_rf && rd_q != '0 && !err_q)
                        regs[rd_q] <= result_q;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the data memory is deliberately not reset; rst only gates the write so an in-flight store is cancelled.
    always_ff @(posedge clk) begin
        if (!rst && state == S_MEM && op_q == OP_SD && !oob)
            mem[addr] <= b_q;
    end

    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
endmodule
